// File: rtl/mips_md_pkg.sv
// Shared opcodes, FSM states and write-back kinds for the EX-stage multiply/divide unit.
package mips_md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // What happens to {hi,lo} when a long operation completes.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_SET  = 2'd1,
    WB_ADD  = 2'd2,
    WB_SUB  = 2'd3
  } md_wb_e;

endpackage

// File: rtl/md_latency_ctr.sv
// Loadable down-counter; done is high while enabled and the count has reached zero.
module md_latency_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - 1'b1;
  end

  assign done = en & (count == '0);

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage MULT/DIV/MTHI/MTLO unit holding HI/LO with modelled multi-cycle latency.
// Define MULDIV_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate opcodes.
//
// state   | meaning
// MD_IDLE | no operation in flight; accepts start
// MD_RUN  | latency counter running; result written to HI/LO when it expires
module ex_muldiv_unit
  import mips_md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        md_use_d,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_md
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e state_q, state_d;
  md_wb_e    pend_wb_q, start_wb, acc_wb;
  logic [63:0] pend_val_q, start_val, hilo_d, prod;
  logic        is_long, is_div, mul_sgn, div_sgn, pend_ld, ctr_load, ctr_done;
  logic [CW-1:0] ctr_val;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag, q_mag, r_mag, quo, rem;

  always_comb begin
    is_long = 1'b0;
    is_div  = 1'b0;
    mul_sgn = 1'b0;
    div_sgn = 1'b0;
    acc_wb  = WB_SET;
    case (op)
      MD_MULT:  begin is_long = 1'b1; mul_sgn = 1'b1; end
      MD_MULTU: is_long = 1'b1;
      MD_DIV:   begin is_long = 1'b1; is_div = 1'b1; div_sgn = 1'b1; end
      MD_DIVU:  begin is_long = 1'b1; is_div = 1'b1; end
`ifdef MULDIV_MADD_EN
      MD_MADD:  begin is_long = 1'b1; mul_sgn = 1'b1; acc_wb = WB_ADD; end
      MD_MADDU: begin is_long = 1'b1; acc_wb = WB_ADD; end
      MD_MSUB:  begin is_long = 1'b1; mul_sgn = 1'b1; acc_wb = WB_SUB; end
      MD_MSUBU: begin is_long = 1'b1; acc_wb = WB_SUB; end
`endif
      default: ;
    endcase
  end

  // Low 64 bits of a product of sign/zero-extended operands give both signed and unsigned results.
  assign prod = {{32{mul_sgn & rs_e[31]}}, rs_e} * {{32{mul_sgn & rt_e[31]}}, rt_e};

  // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow corner.
  assign rs_neg = div_sgn & rs_e[31];
  assign rt_neg = div_sgn & rt_e[31];
  assign rs_mag = rs_neg ? (~rs_e + 32'd1) : rs_e;
  assign rt_mag = rt_neg ? (~rt_e + 32'd1) : rt_e;
  assign q_mag  = (rt_mag != 32'd0) ? (rs_mag / rt_mag) : 32'd0;
  assign r_mag  = (rt_mag != 32'd0) ? (rs_mag % rt_mag) : 32'd0;
  assign quo    = (rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = rs_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    start_val = prod;
    start_wb  = acc_wb;
    if (is_div) begin
      start_val = {rem, quo};
      start_wb  = (rt_e == 32'd0) ? WB_NONE : WB_SET;
    end
  end

  always_comb begin
    state_d  = state_q;
    hilo_d   = {hi, lo};
    pend_ld  = 1'b0;
    ctr_load = 1'b0;
    ctr_val  = '0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (is_long) begin
            pend_ld  = 1'b1;
            ctr_load = 1'b1;
            ctr_val  = is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            state_d  = MD_RUN;
          end else if (op == MD_MTHI) begin
            hilo_d[63:32] = rs_e;
          end else if (op == MD_MTLO) begin
            hilo_d[31:0] = rs_e;
          end
        end
      end
      MD_RUN: begin
        if (ctr_done) begin
          state_d = MD_IDLE;
          case (pend_wb_q)
            WB_SET:  hilo_d = pend_val_q;
            WB_ADD:  hilo_d = {hi, lo} + pend_val_q;
            WB_SUB:  hilo_d = {hi, lo} - pend_val_q;
            default: ;
          endcase
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MD_IDLE;
      hi         <= '0;
      lo         <= '0;
      pend_val_q <= '0;
      pend_wb_q  <= WB_NONE;
    end else begin
      state_q  <= state_d;
      hi       <= hilo_d[63:32];
      lo       <= hilo_d[31:0];
      if (pend_ld) begin
        pend_val_q <= start_val;
        pend_wb_q  <= start_wb;
      end
    end
  end

  md_latency_ctr #(.WIDTH(CW)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (ctr_val),
    .en       (state_q == MD_RUN),
    .done     (ctr_done)
  );

  assign busy     = (state_q == MD_RUN);
  assign stall_md = md_use_d & (busy | (start & is_long));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table with a result scoreboard plus corner sequences.
module tb_ex_muldiv_unit;
  import mips_md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = MD_NONE;
  logic [31:0] rs_e = '0, rt_e = '0;
  logic        md_use_d = 1'b0;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_pass = 0;

  ex_muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_e(rs_e), .rt_e(rt_e),
    .md_use_d(md_use_d), .busy(busy), .hi(hi), .lo(lo), .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, hi, lo;
    int          cyc;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          cyc;
    string       name;
  } exp_t;

  vec_t vt[$];
  exp_t exp_q[$];
  logic [31:0] prev_hi = '0, prev_lo = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, req);
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] h, input logic [31:0] l, input int c, input string n);
    vec_t v;
    v.op = o; v.rs = a; v.rt = b; v.hi = h; v.lo = l; v.cyc = c; v.name = n;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   hold_ok;
    @(negedge clk);
    start = 1'b1; op = v.op; rs_e = v.rs; rt_e = v.rt;
    e.hi = v.hi; e.lo = v.lo; e.cyc = v.cyc; e.name = v.name;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE;
    cyc = 0;
    hold_ok = 1'b1;
    while (busy && cyc < 200) begin
      if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    got = exp_q.pop_front();
    check({got.name, " cycles"}, 32'(cyc), 32'(got.cyc));
    check({got.name, " hold"}, {31'd0, hold_ok}, 32'd1);
    check({got.name, " hi"}, hi, got.hi);
    check({got.name, " lo"}, lo, got.lo);
    prev_hi = got.hi;
    prev_lo = got.lo;
  endtask

  initial begin
    int cyc;
    int stall_cnt;
    bit stall_ok;

    vt.push_back(mk(MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC, "mult_neg"));
    vt.push_back(mk(MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC, "multu"));
    vt.push_back(mk(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC, "div_neg"));
    vt.push_back(mk(MD_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, DC, "divu_zero"));
    vt.push_back(mk(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC, "div_ovf"));
    vt.push_back(mk(MD_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, DC, "divu"));
    vt.push_back(mk(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC, "div_negdiv"));
    vt.push_back(mk(MD_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFD, 0,  "mthi"));
    vt.push_back(mk(MD_MTLO,  32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0,  "mtlo"));
    vt.push_back(mk(MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, MC, "mult_max"));
    vt.push_back(mk(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC, "mult_min"));
    vt.push_back(mk(MD_DIV,   32'd9,        32'd0,        32'h40000000, 32'h00000000, DC, "div_zero"));
`ifdef MULDIV_MADD_EN
    vt.push_back(mk(MD_MADD,  32'd5,        32'd5,        32'h40000000, 32'h00000019, MC, "madd"));
`else
    vt.push_back(mk(MD_MADD,  32'd5,        32'd5,        32'h40000000, 32'h00000000, 0,  "madd_noop"));
`endif

    #12;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vt[i]) run_vec(vt[i]);

    // stall request: combinational on the start cycle, then follows busy
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; rs_e = 32'd0; md_use_d = 1'b1;
    #1 check("stall mthi", {31'd0, stall_md}, 32'd0);
    op = MD_MULT; md_use_d = 1'b0;
    #1 check("stall no use", {31'd0, stall_md}, 32'd0);
    md_use_d = 1'b1; rs_e = 32'd3; rt_e = 32'd4;
    #1 check("stall start", {31'd0, stall_md}, 32'd1);
    stall_cnt = 1;
    stall_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE;
    cyc = 0;
    while (busy && cyc < 200) begin
      if (stall_md !== 1'b1) stall_ok = 1'b0;
      stall_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check("stall tracks busy", {31'd0, stall_ok}, 32'd1);
    check("stall cycles", 32'(stall_cnt), 32'(MC + 1));
    check("stall after", {31'd0, stall_md}, 32'd0);
    check("stall mult lo", lo, 32'd12);
    md_use_d = 1'b0;

    // start while busy must be ignored
    @(negedge clk);
    start = 1'b1; op = MD_MULT; rs_e = 32'd6; rt_e = 32'd7;
    @(posedge clk); #1;
    @(negedge clk);
    op = MD_MTHI; rs_e = 32'hDEAD;
    @(posedge clk); #1;
    op = MD_DIV; rs_e = 32'd100; rt_e = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE;
    cyc = 2;
    while (busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ign cycles", 32'(cyc), 32'(MC));
    check("ign hi", hi, 32'd0);
    check("ign lo", lo, 32'd42);
    prev_hi = 32'd0;
    prev_lo = 32'd42;

    // reset in the middle of a divide
    run_vec(mk(MD_MTHI, 32'h55, 32'd0, 32'h00000055, 32'd42, 0, "mthi_pre"));
    @(negedge clk);
    start = 1'b1; op = MD_DIV; rs_e = 32'd100; rt_e = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE;
    repeat (2) @(posedge clk);
    #1 check("pre-rst busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid-rst busy", {31'd0, busy}, 32'd0);
    check("mid-rst hi", hi, 32'd0);
    check("mid-rst lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (DC + 5) @(posedge clk);
    #1;
    check("late busy", {31'd0, busy}, 32'd0);
    check("late hi", hi, 32'd0);
    check("late lo", lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
